// File: rtl/prio_grant_issuer.sv
// Priority grant issuer: accepts a request word and presents one-hot grants lane by lane,
// lowest index first. Each grant is held until it is acknowledged or its hold timer expires.
module prio_grant_issuer #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15,
    parameter int IDXW     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_vec,
    input  logic             sel_in,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_valid,
    input  logic             grant_ack,
    output logic [WIDTH-1:0] grant_onehot,
    output logic [IDXW-1:0]  grant_idx,
    output logic             grant_bit,
    output logic             done,
    output logic             timeout_err
);

    // Keep the timer at least one bit wide so HOLD_MAX=0 still elaborates.
    localparam int TW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] low_onehot;
    logic [IDXW-1:0]  low_idx;
    logic             hit_timeout;

    always_comb begin
        low_onehot = pend_q & (~pend_q + WIDTH'(1));
        low_idx    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = IDXW'(i);
        end
    end

    assign hit_timeout = (HOLD_MAX > 0) && !grant_ack && (timer_q == TW'(HOLD_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            word_q    <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            word_q    <= word_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        word_d    = word_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    pend_d  = req_vec;
                    word_d  = ~(sel_in ? data_a : data_b);
                    timer_d = '0;
                    state_d = (req_vec == '0) ? StDone : StGrant;
                end
            end
            StGrant: begin
                if (grant_ack || hit_timeout) begin
                    pend_d    = pend_q & ~low_onehot;
                    timer_d   = '0;
                    timeout_d = hit_timeout;
                    if ((pend_q & ~low_onehot) == '0) state_d = StDone;
                end else if (timer_q != '1) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    timer_d = timer_q + TW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == StIdle);
        grant_valid  = (state_q == StGrant);
        grant_onehot = grant_valid ? low_onehot : '0;
        grant_idx    = grant_valid ? low_idx : '0;
        grant_bit    = grant_valid & word_q[low_idx];
        done         = (state_q == StDone);
        timeout_err  = timeout_q;
    end

endmodule
